// File: rtl/data_mem_io.sv
// Data-side memory stage: 252-byte RAM plus memory-mapped timer, shadow, switch and LED bytes.
// Loads are combinational; stores, timer and synchronizer update on the rising CLK edge.
module data_mem_io #(
   parameter int PRESCALE = 1,
   parameter int TIMER_W  = 16
) (
   input  logic       CLK,
   input  logic       RESET_L,
   input  logic [7:0] ADDR,
   input  logic [7:0] WDATA,
   input  logic       MW,
   input  logic       MR,
   output logic [7:0] RDATA,
   input  logic [7:0] SW,
   output logic [7:0] LED,
   output logic       TICK
);

   localparam int         RAM_N   = 252;
   localparam logic [7:0] A_TLO   = 8'hFC;
   localparam logic [7:0] A_THI   = 8'hFD;
   localparam logic [7:0] A_SW    = 8'hFE;
   localparam logic [7:0] A_LED   = 8'hFF;
   localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

   logic [7:0]         ram_q [RAM_N];
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [7:0]         ps_q, ps_d;
   logic [7:0]         shadow_q, shadow_d;
   logic [7:0]         led_q, led_d;
   logic [7:0]         sync1_q, sync2_q;
   logic               tick_q, tick_d;
   logic               wr_ram, clr_timer;

   assign wr_ram    = MW && (ADDR < A_TLO);
   assign clr_timer = MW && (ADDR == A_TLO);

   // A clear of the timer wins over a tick due on the same edge.
   always_comb begin
      timer_d  = timer_q;
      ps_d     = ps_q;
      tick_d   = 1'b0;
      shadow_d = shadow_q;
      led_d    = led_q;
      if (clr_timer) begin
         timer_d = '0;
         ps_d    = '0;
      end else if (ps_q == PS_LAST) begin
         timer_d = timer_q + TIMER_W'(1);
         ps_d    = '0;
         tick_d  = 1'b1;
      end else begin
         ps_d = ps_q + 8'd1;
      end
      // Capture uses the pre-increment high byte so TIMER_LO and TIMER_HI_SHADOW pair up.
      if (MR && (ADDR == A_TLO))
         shadow_d = timer_q[15:8];
      if (MW && (ADDR == A_LED))
         led_d = WDATA;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         for (int i = 0; i < RAM_N; i++)
            ram_q[i] <= 8'h00;
         timer_q  <= '0;
         ps_q     <= '0;
         tick_q   <= 1'b0;
         shadow_q <= '0;
         led_q    <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
      end else begin
         if (wr_ram)
            ram_q[ADDR] <= WDATA;
         timer_q  <= timer_d;
         ps_q     <= ps_d;
         tick_q   <= tick_d;
         shadow_q <= shadow_d;
         led_q    <= led_d;
         sync1_q  <= SW;
         sync2_q  <= sync1_q;
      end
   end

   always_comb begin
      case (ADDR)
         A_TLO:   RDATA = timer_q[7:0];
         A_THI:   RDATA = shadow_q;
         A_SW:    RDATA = sync2_q;
         A_LED:   RDATA = led_q;
         default: RDATA = ram_q[ADDR];
      endcase
   end

   assign LED  = led_q;
   assign TICK = tick_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: one instance at PRESCALE=1, one at PRESCALE=4, sharing all inputs.
module tb_data_mem_io;

   logic       CLK = 1'b0;
   logic       RESET_L;
   logic [7:0] ADDR, WDATA, SW;
   logic       MW, MR;
   logic [7:0] RDATA1, LED1, RDATA4, LED4;
   logic       TICK1, TICK4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         src;
      logic [7:0] exp;
      string      tag;
   } exp_t;
   exp_t sbq[$];

   always #5 CLK = ~CLK;

   data_mem_io #(.PRESCALE(1), .TIMER_W(16)) dut1 (
      .CLK(CLK), .RESET_L(RESET_L), .ADDR(ADDR), .WDATA(WDATA), .MW(MW), .MR(MR),
      .RDATA(RDATA1), .SW(SW), .LED(LED1), .TICK(TICK1));

   data_mem_io #(.PRESCALE(4), .TIMER_W(16)) dut4 (
      .CLK(CLK), .RESET_L(RESET_L), .ADDR(ADDR), .WDATA(WDATA), .MW(MW), .MR(MR),
      .RDATA(RDATA4), .SW(SW), .LED(LED4), .TICK(TICK4));

   function automatic logic [7:0] observe(input int src);
      case (src)
         0:       return RDATA1;
         1:       return LED1;
         2:       return {7'd0, TICK1};
         3:       return RDATA4;
         default: return {7'd0, TICK4};
      endcase
   endfunction

   task automatic expect_v(input int src, input logic [7:0] e, input string tag);
      exp_t it;
      it.src = src;
      it.exp = e;
      it.tag = tag;
      sbq.push_back(it);
   endtask

   task automatic compare_all();
      exp_t       it;
      logic [7:0] obs;
      #1;
      while (sbq.size() > 0) begin
         it  = sbq.pop_front();
         obs = observe(it.src);
         checks++;
         assert (obs === it.exp)
         else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic peek(input int src, input logic [7:0] a, input logic [7:0] e, input string tag);
      ADDR = a;
      expect_v(src, e, tag);
      compare_all();
   endtask

   task automatic chk(input int src, input logic [7:0] e, input string tag);
      expect_v(src, e, tag);
      compare_all();
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic store(input logic [7:0] a, input logic [7:0] d);
      MW = 1'b1; ADDR = a; WDATA = d;
      cyc();
      MW = 1'b0;
   endtask

   initial begin
      RESET_L = 1'b0; MW = 1'b0; MR = 1'b0; ADDR = 8'h00; WDATA = 8'h00; SW = 8'h00;
      repeat (3) cyc();
      RESET_L = 1'b1;

      // first cycle after release
      peek(0, 8'h10, 8'h00, "rst_ram10");
      peek(0, 8'hFF, 8'h00, "rst_led_rd");
      peek(0, 8'hFD, 8'h00, "rst_shadow");
      peek(0, 8'hFC, 8'h00, "rst_timer");
      chk(1, 8'h00, "rst_led");
      chk(2, 8'h00, "rst_tick");
      cyc();
      peek(0, 8'hFC, 8'h01, "timer_1");
      chk(2, 8'h01, "tick_1");
      cyc();
      peek(0, 8'hFC, 8'h02, "timer_2");

      // RAM traffic with read-during-write
      MW = 1'b1; ADDR = 8'h20; WDATA = 8'hA5;
      chk(0, 8'h00, "rdw_20_old0");
      cyc(); MW = 1'b0;
      peek(0, 8'h20, 8'hA5, "ram20_a5");
      MW = 1'b1; ADDR = 8'h20; WDATA = 8'h77;
      chk(0, 8'hA5, "rdw_20_oldA5");
      cyc(); MW = 1'b0;
      peek(0, 8'h20, 8'h77, "ram20_77");
      store(8'hFB, 8'h3C);
      peek(0, 8'hFB, 8'h3C, "ramFB");
      peek(0, 8'hFA, 8'h00, "ramFA_untouched");

      // LED and read-only bytes
      store(8'hFF, 8'h81);
      chk(1, 8'h81, "led_out");
      peek(0, 8'hFF, 8'h81, "led_rd");
      store(8'hFE, 8'hEE);
      peek(0, 8'hFE, 8'h00, "swin_ro");
      store(8'hFD, 8'h55);
      peek(0, 8'hFD, 8'h00, "shadow_ro");

      // timer clear, 0x1FF run, coherent shadow capture
      store(8'hFC, 8'h00);
      peek(0, 8'hFC, 8'h00, "clr_timer");
      chk(2, 8'h00, "clr_tick_supp");
      repeat (16'h01FF) cyc();
      MR = 1'b1;
      peek(0, 8'hFC, 8'hFF, "t1ff_lo");
      cyc(); MR = 1'b0;
      peek(0, 8'hFD, 8'h01, "t1ff_hi");
      peek(0, 8'hFC, 8'h00, "t200_lo");

      // run to 0xFFFF and wrap
      store(8'hFC, 8'h00);
      repeat (16'hFFFF) cyc();
      MR = 1'b1;
      peek(0, 8'hFC, 8'hFF, "tffff_lo");
      cyc(); MR = 1'b0;
      peek(0, 8'hFD, 8'hFF, "tffff_hi");
      MR = 1'b1;
      peek(0, 8'hFC, 8'h00, "wrap_lo");
      cyc(); MR = 1'b0;
      peek(0, 8'hFD, 8'h00, "wrap_hi");
      peek(0, 8'hFC, 8'h01, "wrap_next");

      // PRESCALE=4 instance
      store(8'hFC, 8'h00);
      peek(3, 8'hFC, 8'h00, "p4_clr");
      chk(4, 8'h00, "p4_clr_tick");
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            cyc();
            chk(4, 8'h00, $sformatf("p4_notick_%0d_%0d", k, j));
            peek(3, 8'hFC, 8'(k), $sformatf("p4_hold_%0d_%0d", k, j));
         end
         cyc();
         chk(4, 8'h01, $sformatf("p4_tick_%0d", k));
         peek(3, 8'hFC, 8'(k + 1), $sformatf("p4_inc_%0d", k));
      end
      repeat (3) cyc();
      chk(4, 8'h00, "p4_pre_clr_tick");
      store(8'hFC, 8'h00);
      peek(3, 8'hFC, 8'h00, "p4_clr_on_tick");
      chk(4, 8'h00, "p4_tick_suppressed");
      repeat (3) cyc();
      chk(4, 8'h00, "p4_after_clr_quiet");
      cyc();
      chk(4, 8'h01, "p4_after_clr_tick");
      peek(3, 8'hFC, 8'h01, "p4_after_clr_inc");

      // switch synchronizer
      SW = 8'h5A;
      cyc();
      peek(0, 8'hFE, 8'h00, "sw_edge1");
      cyc();
      peek(0, 8'hFE, 8'h5A, "sw_edge2");

      // reset during a store
      RESET_L = 1'b0; MW = 1'b1; ADDR = 8'h30; WDATA = 8'h99;
      cyc();
      RESET_L = 1'b1; MW = 1'b0;
      peek(0, 8'h30, 8'h00, "rst_store30");
      peek(0, 8'h20, 8'h00, "rst_ram20");
      peek(0, 8'hFC, 8'h00, "rst_mid_timer");
      peek(0, 8'hFE, 8'h00, "rst_mid_sw");
      chk(1, 8'h00, "rst_mid_led");
      chk(2, 8'h00, "rst_mid_tick");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
